// File: rtl/ramfu_rs_if.sv
// Bus bundle between the dispatch/CDB/FU side and the RAM FU reservation station.
// Handshake: a dispatch is taken on a clock edge where disp_valid=1, full=0 and
// flush=0 (full is the ready signal, inverted); the station issues by pulsing
// input_transmit for exactly one cycle with the op fields, and the FU holds it
// back by raising fu_busy.
interface ramfu_rs_if #(
  parameter int TAG_W = 4
) ();
  logic                  flush;
  logic                  disp_valid;
  logic [7:0]            disp_operand;
  logic [1:0][7:0]       disp_depvals;
  logic [1:0][TAG_W-1:0] disp_deptags;
  logic [1:0]            disp_depready;
  logic [7:0]            disp_wbs;
  logic [7:0]            disp_flags;
  logic [TAG_W-1:0]      disp_robid;
  logic                  full;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_id;
  logic [7:0]            cdb_val;
  logic                  fu_busy;
  logic                  input_transmit;
  logic [7:0]            operand;
  logic [1:0][7:0]       depvals;
  logic [7:0]            wbs;
  logic [7:0]            flags;
  logic [TAG_W-1:0]      robid;

  modport master (
    output flush, disp_valid, disp_operand, disp_depvals, disp_deptags,
           disp_depready, disp_wbs, disp_flags, disp_robid,
           cdb_valid, cdb_id, cdb_val, fu_busy,
    input  full, input_transmit, operand, depvals, wbs, flags, robid
  );

  modport slave (
    input  flush, disp_valid, disp_operand, disp_depvals, disp_deptags,
           disp_depready, disp_wbs, disp_flags, disp_robid,
           cdb_valid, cdb_id, cdb_val, fu_busy,
    output full, input_transmit, operand, depvals, wbs, flags, robid
  );
endinterface

// File: rtl/ramfu_rs.sv
// In-order reservation station feeding the RAM functional unit. Ops sit in a
// circular FIFO, wake their sources from the CDB, and leave strictly from the
// head so memory sees loads and stores in program order.
module ramfu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic      clk,
  input logic      rst,
  ramfu_rs_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  r_valid   [DEPTH];
  logic [7:0]            r_operand [DEPTH];
  logic [1:0][7:0]       r_val     [DEPTH];
  logic [1:0][TAG_W-1:0] r_tag     [DEPTH];
  logic [1:0]            r_rdy     [DEPTH];
  logic [7:0]            r_wbs     [DEPTH];
  logic [7:0]            r_flags   [DEPTH];
  logic [TAG_W-1:0]      r_robid   [DEPTH];

  logic                  r_tx;
  logic [7:0]            r_out_operand;
  logic [1:0][7:0]       r_out_depvals;
  logic [7:0]            r_out_wbs;
  logic [7:0]            r_out_flags;
  logic [TAG_W-1:0]      r_out_robid;

  logic                  w_full;
  logic                  w_disp;
  logic                  w_issue;
  logic [1:0]            w_head_rdy;
  logic [1:0][7:0]       w_head_val;
  logic [1:0]            w_disp_rdy;
  logic [1:0][7:0]       w_disp_val;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_disp = bus.disp_valid && !w_full && !bus.flush;

  // Head readiness including a same-cycle CDB hit, so a wake issues next cycle.
  always_comb begin
    w_head_rdy = '0;
    w_head_val = '0;
    for (int s = 0; s < 2; s++) begin
      w_head_rdy[s] = r_rdy[r_head][s] ||
                      (bus.cdb_valid && (bus.cdb_id == r_tag[r_head][s]));
      w_head_val[s] = r_rdy[r_head][s] ? r_val[r_head][s] : bus.cdb_val;
    end
    w_issue = r_valid[r_head] && (&w_head_rdy) && !bus.fu_busy && !bus.flush;
  end

  // Source capture for an incoming dispatch: dispatch value first, else CDB.
  always_comb begin
    w_disp_rdy = '0;
    w_disp_val = '0;
    for (int s = 0; s < 2; s++) begin
      if (bus.disp_depready[s]) begin
        w_disp_rdy[s] = 1'b1;
        w_disp_val[s] = bus.disp_depvals[s];
      end else if (bus.cdb_valid && (bus.cdb_id == bus.disp_deptags[s])) begin
        w_disp_rdy[s] = 1'b1;
        w_disp_val[s] = bus.cdb_val;
      end else begin
        w_disp_rdy[s] = 1'b0;
        w_disp_val[s] = bus.disp_depvals[s];
      end
    end
  end

  // FIFO state, CDB snoop, head issue and tail dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_tx          <= 1'b0;
      r_out_operand <= '0;
      r_out_depvals <= '0;
      r_out_wbs     <= '0;
      r_out_flags   <= '0;
      r_out_robid   <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_tx    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int s = 0; s < 2; s++) begin
          if (r_valid[i] && !r_rdy[i][s] && bus.cdb_valid &&
              (bus.cdb_id == r_tag[i][s])) begin
            r_val[i][s] <= bus.cdb_val;
            r_rdy[i][s] <= 1'b1;
          end
        end
      end

      r_tx <= w_issue;
      if (w_issue) begin
        r_out_operand   <= r_operand[r_head];
        r_out_depvals   <= w_head_val;
        r_out_wbs       <= r_wbs[r_head];
        r_out_flags     <= r_flags[r_head];
        r_out_robid     <= r_robid[r_head];
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end

      if (w_disp) begin
        r_valid[r_tail]   <= 1'b1;
        r_operand[r_tail] <= bus.disp_operand;
        r_val[r_tail]     <= w_disp_val;
        r_tag[r_tail]     <= bus.disp_deptags;
        r_rdy[r_tail]     <= w_disp_rdy;
        r_wbs[r_tail]     <= bus.disp_wbs;
        r_flags[r_tail]   <= bus.disp_flags;
        r_robid[r_tail]   <= bus.disp_robid;
        r_tail            <= r_tail + PTR_W'(1);
      end

      case ({w_disp, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.full           = w_full;
  assign bus.input_transmit = r_tx;
  assign bus.operand        = r_out_operand;
  assign bus.depvals        = r_out_depvals;
  assign bus.wbs            = r_out_wbs;
  assign bus.flags          = r_out_flags;
  assign bus.robid          = r_out_robid;
endmodule

// File: tb/tb_ramfu_rs.sv
// Bench for ramfu_rs: directed scenarios plus random traffic, checked against a
// queue-based model of the station and an issue-order scoreboard.
module tb_ramfu_rs;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int OBS_W = 1 + 1 + 8 + 16 + 8 + 8 + TAG_W;

  typedef struct {
    logic [7:0]            operand;
    logic [1:0][7:0]       vals;
    logic [1:0][TAG_W-1:0] tags;
    logic [1:0]            rdy;
    logic [7:0]            wbs;
    logic [7:0]            flags;
    logic [TAG_W-1:0]      robid;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ramfu_rs_if #(.TAG_W(TAG_W)) rs_if ();

  ramfu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rs_if)
  );

  // ---------------- model state ----------------
  ent_t             m_q[$];
  logic             m_tx;
  logic             m_full;
  logic [7:0]       m_operand;
  logic [1:0][7:0]  m_depvals;
  logic [7:0]       m_wbs;
  logic [7:0]       m_flags;
  logic [TAG_W-1:0] m_robid;

  logic [OBS_W-1:0] obs_v;
  logic [OBS_W-1:0] exp_v;
  logic [7:0]       exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model of one clock edge, using the inputs present at that edge.
  task automatic m_step();
    ent_t e;
    logic ok;
    logic was_full;
    if (rst) begin
      m_q.delete();
      m_tx = 0; m_operand = 0; m_depvals = 0; m_wbs = 0; m_flags = 0; m_robid = 0;
    end else if (rs_if.flush) begin
      m_q.delete();
      m_tx = 0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      m_tx = 0;
      if (m_q.size() > 0 && !rs_if.fu_busy) begin
        e = m_q[0];
        ok = 1;
        for (int s = 0; s < 2; s++) begin
          if (!e.rdy[s]) begin
            if (rs_if.cdb_valid && rs_if.cdb_id == e.tags[s]) e.vals[s] = rs_if.cdb_val;
            else ok = 0;
          end
        end
        if (ok) begin
          m_tx = 1;
          m_operand = e.operand; m_depvals = e.vals; m_wbs = e.wbs;
          m_flags = e.flags; m_robid = e.robid;
          void'(m_q.pop_front());
        end
      end
      for (int k = 0; k < m_q.size(); k++) begin
        e = m_q[k];
        for (int s = 0; s < 2; s++) begin
          if (!e.rdy[s] && rs_if.cdb_valid && rs_if.cdb_id == e.tags[s]) begin
            e.rdy[s] = 1; e.vals[s] = rs_if.cdb_val;
          end
        end
        m_q[k] = e;
      end
      if (rs_if.disp_valid && !was_full) begin
        e.operand = rs_if.disp_operand;
        e.tags    = rs_if.disp_deptags;
        e.wbs     = rs_if.disp_wbs;
        e.flags   = rs_if.disp_flags;
        e.robid   = rs_if.disp_robid;
        for (int s = 0; s < 2; s++) begin
          e.vals[s] = rs_if.disp_depvals[s];
          e.rdy[s]  = rs_if.disp_depready[s];
          if (!e.rdy[s] && rs_if.cdb_valid && rs_if.cdb_id == e.tags[s]) begin
            e.rdy[s] = 1; e.vals[s] = rs_if.cdb_val;
          end
        end
        m_q.push_back(e);
      end
    end
    m_full = (m_q.size() == DEPTH);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    obs_v = {rs_if.input_transmit, rs_if.full, rs_if.operand, rs_if.depvals,
             rs_if.wbs, rs_if.flags, rs_if.robid};
    exp_v = {m_tx, m_full, m_operand, m_depvals, m_wbs, m_flags, m_robid};
  endtask

  task automatic idle_inputs();
    rs_if.flush = 0;
    rs_if.disp_valid = 0;
    rs_if.disp_operand = 0;
    rs_if.disp_depvals = 0;
    rs_if.disp_deptags = 0;
    rs_if.disp_depready = 2'b11;
    rs_if.disp_wbs = 0;
    rs_if.disp_flags = 0;
    rs_if.disp_robid = 0;
    rs_if.cdb_valid = 0;
    rs_if.cdb_id = 0;
    rs_if.cdb_val = 0;
    rs_if.fu_busy = 0;
  endtask

  task automatic drive_disp(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input logic [TAG_W-1:0] tag_a,
                            input logic [TAG_W-1:0] tag_d, input logic [1:0] rdy);
    rs_if.disp_valid      = 1;
    rs_if.disp_operand    = op;
    rs_if.disp_depvals[1] = addr;
    rs_if.disp_depvals[0] = data;
    rs_if.disp_deptags[1] = tag_a;
    rs_if.disp_deptags[0] = tag_d;
    rs_if.disp_depready   = rdy;
    rs_if.disp_wbs        = 8'($urandom_range(0, 255));
    rs_if.disp_flags      = 8'($urandom_range(0, 255));
    rs_if.disp_robid      = TAG_W'($urandom_range(0, 15));
  endtask

  task automatic stop_disp();
    rs_if.disp_valid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    drive_disp(8'h3C, 8'h11, 8'h22, 0, 0, 2'b11);
    rs_if.cdb_valid = 1;
    tick();
    tick();
    n_checks++;
    if (obs_v !== '0) $display("FAIL reset_outputs: got %h want 0", obs_v);
    else n_pass++;
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL reset_model: got %h want %h", obs_v, exp_v);
    else n_pass++;
    rst = 0;
    idle_inputs();
    tick();
    n_checks++;
    if (obs_v !== '0) $display("FAIL reset_idle: got %h want 0", obs_v);
    else n_pass++;
  endtask

  task automatic test_ready_dispatch();
    logic [7:0] op;
    op = 8'($urandom_range(0, 255));
    drive_disp(op, 8'h10, 8'h55, 0, 0, 2'b11);
    tick();
    stop_disp();
    n_checks++;
    if (rs_if.input_transmit !== 1'b0) $display("FAIL ready_early: got %b want 0", rs_if.input_transmit);
    else n_pass++;
    tick();
    n_checks++;
    if ({rs_if.input_transmit, rs_if.operand, rs_if.depvals} !== {1'b1, op, 8'h10, 8'h55})
      $display("FAIL ready_issue: got %b %h %h want 1 %h 1055", rs_if.input_transmit,
               rs_if.operand, rs_if.depvals, op);
    else n_pass++;
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL ready_model: got %h want %h", obs_v, exp_v);
    else n_pass++;
    tick();
    n_checks++;
    if ({rs_if.input_transmit, rs_if.depvals} !== {1'b0, 8'h10, 8'h55})
      $display("FAIL ready_hold: got %b %h want 0 1055", rs_if.input_transmit, rs_if.depvals);
    else n_pass++;
  endtask

  task automatic test_cdb_wake();
    drive_disp(8'h61, 8'h00, 8'h77, 4'd3, 4'd0, 2'b01);
    tick();
    stop_disp();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rs_if.input_transmit !== 1'b0) $display("FAIL wake_wait: got %b want 0", rs_if.input_transmit);
      else n_pass++;
      tick();
    end
    rs_if.cdb_valid = 1; rs_if.cdb_id = 4'd3; rs_if.cdb_val = 8'h20;
    tick();
    rs_if.cdb_valid = 0;
    n_checks++;
    if ({rs_if.input_transmit, rs_if.depvals} !== {1'b1, 8'h20, 8'h77})
      $display("FAIL wake_issue: got %b %h want 1 2077", rs_if.input_transmit, rs_if.depvals);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL wake_model: got %h want %h", obs_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_in_order();
    drive_disp(8'hA1, 8'h00, 8'h01, 4'd5, 4'd0, 2'b01);
    tick();
    drive_disp(8'hB2, 8'h02, 8'h03, 4'd0, 4'd0, 2'b11);
    tick();
    stop_disp();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (rs_if.input_transmit !== 1'b0) $display("FAIL order_blocked: got %b want 0", rs_if.input_transmit);
      else n_pass++;
    end
    rs_if.cdb_valid = 1; rs_if.cdb_id = 4'd5; rs_if.cdb_val = 8'($urandom_range(0, 255));
    tick();
    rs_if.cdb_valid = 0;
    n_checks++;
    if ({rs_if.input_transmit, rs_if.operand} !== {1'b1, 8'hA1})
      $display("FAIL order_first: got %b %h want 1 a1", rs_if.input_transmit, rs_if.operand);
    else n_pass++;
    tick();
    n_checks++;
    if ({rs_if.input_transmit, rs_if.operand} !== {1'b1, 8'hB2})
      $display("FAIL order_second: got %b %h want 1 b2", rs_if.input_transmit, rs_if.operand);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL order_model: got %h want %h", obs_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    logic [7:0] op;
    int added;
    int issued;
    exp_q.delete();
    rs_if.fu_busy = 1;
    for (int k = 0; k < DEPTH; k++) begin
      op = 8'($urandom_range(0, 255));
      drive_disp(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 2'b11);
      exp_q.push_back(op);
      tick();
    end
    stop_disp();
    n_checks++;
    if (rs_if.full !== 1'b1) $display("FAIL full_flag: got %b want 1", rs_if.full);
    else n_pass++;
    drive_disp(8'hEE, 8'h00, 8'h00, 0, 0, 2'b11);
    tick();
    stop_disp();
    n_checks++;
    if ({rs_if.full, rs_if.input_transmit} !== 2'b10)
      $display("FAIL full_drop: got %b%b want 10", rs_if.full, rs_if.input_transmit);
    else n_pass++;
    rs_if.fu_busy = 0;
    added = 0;
    issued = 0;
    for (int c = 0; c < 40; c++) begin
      if (added < 8) begin
        op = 8'($urandom_range(0, 255));
        drive_disp(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 2'b11);
        if (!m_full) begin
          exp_q.push_back(op);
          added++;
        end
      end else begin
        stop_disp();
      end
      tick();
      if (rs_if.input_transmit === 1'b1) begin
        issued++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_extra: got %h want none", rs_if.operand);
        else if (rs_if.operand !== exp_q[0])
          $display("FAIL wrap_order: got %h want %h", rs_if.operand, exp_q.pop_front());
        else begin
          n_pass++;
          void'(exp_q.pop_front());
        end
      end
    end
    stop_disp();
    n_checks++;
    if (issued !== 12) $display("FAIL wrap_count: got %0d want 12", issued);
    else n_pass++;
  endtask

  task automatic test_same_cycle_capture();
    drive_disp(8'h5A, 8'h00, 8'h31, 4'd7, 4'd0, 2'b01);
    rs_if.cdb_valid = 1; rs_if.cdb_id = 4'd7; rs_if.cdb_val = 8'hAA;
    tick();
    stop_disp();
    rs_if.cdb_valid = 0;
    tick();
    n_checks++;
    if ({rs_if.input_transmit, rs_if.operand, rs_if.depvals} !== {1'b1, 8'h5A, 8'hAA, 8'h31})
      $display("FAIL capture_issue: got %b %h %h want 1 5a aa31", rs_if.input_transmit,
               rs_if.operand, rs_if.depvals);
    else n_pass++;
  endtask

  task automatic test_flush();
    rs_if.fu_busy = 1;
    for (int k = 0; k < 3; k++) begin
      drive_disp(8'(8'h90 + k), 8'h00, 8'h00, 0, 0, 2'b11);
      tick();
    end
    rs_if.flush = 1;
    drive_disp(8'h9F, 8'h00, 8'h00, 0, 0, 2'b11);
    tick();
    rs_if.flush = 0;
    stop_disp();
    n_checks++;
    if ({rs_if.full, rs_if.input_transmit} !== 2'b00)
      $display("FAIL flush_state: got %b%b want 00", rs_if.full, rs_if.input_transmit);
    else n_pass++;
    rs_if.fu_busy = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (rs_if.input_transmit !== 1'b0) $display("FAIL flush_quiet: got %b want 0", rs_if.input_transmit);
      else n_pass++;
    end
    drive_disp(8'hC4, 8'h12, 8'h34, 0, 0, 2'b11);
    tick();
    stop_disp();
    tick();
    n_checks++;
    if ({rs_if.input_transmit, rs_if.operand} !== {1'b1, 8'hC4})
      $display("FAIL flush_after: got %b %h want 1 c4", rs_if.input_transmit, rs_if.operand);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rs_if.disp_valid      = ($urandom_range(0, 2) != 0);
      rs_if.disp_operand    = 8'($urandom_range(0, 255));
      rs_if.disp_depvals    = 16'($urandom_range(0, 65535));
      rs_if.disp_deptags[1] = TAG_W'($urandom_range(0, 7));
      rs_if.disp_deptags[0] = TAG_W'($urandom_range(0, 7));
      rs_if.disp_depready   = 2'($urandom_range(0, 3));
      rs_if.disp_wbs        = 8'($urandom_range(0, 255));
      rs_if.disp_flags      = 8'($urandom_range(0, 255));
      rs_if.disp_robid      = TAG_W'($urandom_range(0, 15));
      rs_if.cdb_valid       = ($urandom_range(0, 1) != 0);
      rs_if.cdb_id          = TAG_W'($urandom_range(0, 7));
      rs_if.cdb_val         = 8'($urandom_range(0, 255));
      rs_if.fu_busy         = ($urandom_range(0, 2) == 0);
      rs_if.flush           = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL random_c%0d: got %h want %h", c, obs_v, exp_v);
      else n_pass++;
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    m_q.delete();
    m_tx = 0; m_full = 0; m_operand = 0; m_depvals = 0;
    m_wbs = 0; m_flags = 0; m_robid = 0;
    test_reset();
    test_ready_dispatch();
    test_cdb_wake();
    test_in_order();
    test_full_wrap();
    test_same_cycle_capture();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
